// File: rtl/i2c_target.sv
// Two-wire bus target: oversampled SCL/SDA, 7-bit address match, 16-bit write capture / read return.
// Define I2C_TGT_GENCALL_EN to also accept general-call writes to address 7'h00.
module i2c_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h2A
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        SCL,
   input  logic        SDA_IN,
   output logic        SDA_OUT,
   output logic        SDA_OE,
   input  logic [15:0] RD_DATA,
   output logic [15:0] WR_DATA,
   output logic        WR_STB,
   output logic        RD_STB,
   output logic        BUSY
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_BYTE,
      WR_ACK,
      RD_BYTE,
      RD_ACK,
      WAIT_STOP
   } state_t;

   logic scl_m, scl_s, scl_d;
   logic sda_m, sda_s, sda_d;
   logic ev_start, ev_stop, ev_rise, ev_fall, bit_in;

   state_t      state, state_nxt;
   logic [3:0]  bit_cnt, bit_cnt_nxt;
   logic [1:0]  byte_cnt, byte_cnt_nxt;
   logic [15:0] shift, shift_nxt;
   logic        rnw, rnw_nxt;
   logic        sda_oe_nxt, sda_out_nxt, busy_nxt, wr_stb_nxt, rd_stb_nxt;
   logic [15:0] wr_data_nxt;
   logic        addr_hit;

   // Synchronizers run freely so that leaving reset never fabricates a bus edge.
   always_ff @(posedge CLK) begin
      scl_m <= SCL;
      scl_s <= scl_m;
      scl_d <= scl_s;
      sda_m <= SDA_IN;
      sda_s <= sda_m;
      sda_d <= sda_s;
   end

   // Registered bus events; an SCL change on the same cycle suppresses START/STOP.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ev_start <= 1'b0;
         ev_stop  <= 1'b0;
         ev_rise  <= 1'b0;
         ev_fall  <= 1'b0;
         bit_in   <= 1'b1;
      end else begin
         ev_start <= scl_s & scl_d & sda_d & ~sda_s;
         ev_stop  <= scl_s & scl_d & ~sda_d & sda_s;
         ev_rise  <= scl_s & ~scl_d;
         ev_fall  <= ~scl_s & scl_d;
         bit_in   <= sda_s;
      end
   end

`ifdef I2C_TGT_GENCALL_EN
   assign addr_hit = (shift[7:1] == TARGET_ADDR) || ((shift[7:1] == 7'h00) && !shift[0]);
`else
   assign addr_hit = (shift[7:1] == TARGET_ADDR);
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= IDLE;
         bit_cnt  <= 4'd0;
         byte_cnt <= 2'd0;
         shift    <= 16'h0000;
         rnw      <= 1'b0;
         SDA_OE   <= 1'b0;
         SDA_OUT  <= 1'b0;
         WR_DATA  <= 16'h0000;
         WR_STB   <= 1'b0;
         RD_STB   <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_cnt_nxt;
         byte_cnt <= byte_cnt_nxt;
         shift    <= shift_nxt;
         rnw      <= rnw_nxt;
         SDA_OE   <= sda_oe_nxt;
         SDA_OUT  <= sda_out_nxt;
         WR_DATA  <= wr_data_nxt;
         WR_STB   <= wr_stb_nxt;
         RD_STB   <= rd_stb_nxt;
         BUSY     <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      byte_cnt_nxt = byte_cnt;
      shift_nxt    = shift;
      rnw_nxt      = rnw;
      sda_oe_nxt   = SDA_OE;
      sda_out_nxt  = SDA_OUT;
      wr_data_nxt  = WR_DATA;
      wr_stb_nxt   = 1'b0;
      rd_stb_nxt   = 1'b0;
      busy_nxt     = BUSY;

      if (ev_start) begin
         state_nxt    = ADDR;
         bit_cnt_nxt  = 4'd0;
         byte_cnt_nxt = 2'd0;
         sda_oe_nxt   = 1'b0;
         sda_out_nxt  = 1'b0;
         busy_nxt     = 1'b1;
      end else if (ev_stop) begin
         state_nxt   = IDLE;
         sda_oe_nxt  = 1'b0;
         sda_out_nxt = 1'b0;
         busy_nxt    = 1'b0;
      end else begin
         case (state)
            ADDR: begin
               if (ev_rise) begin
                  shift_nxt   = {shift[14:0], bit_in};
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end else if (ev_fall && bit_cnt == 4'd8) begin
                  bit_cnt_nxt = 4'd0;
                  if (addr_hit) begin
                     state_nxt    = ADDR_ACK;
                     sda_oe_nxt   = 1'b1;
                     sda_out_nxt  = 1'b0;
                     rnw_nxt      = shift[0];
                     byte_cnt_nxt = 2'd0;
                     if (shift[0]) begin
                        shift_nxt  = RD_DATA;
                        rd_stb_nxt = 1'b1;
                     end
                  end else begin
                     state_nxt  = WAIT_STOP;
                     sda_oe_nxt = 1'b0;
                  end
               end
            end
            ADDR_ACK: begin
               if (ev_fall) begin
                  if (rnw) begin
                     state_nxt   = RD_BYTE;
                     sda_oe_nxt  = 1'b1;
                     sda_out_nxt = shift[15];
                     shift_nxt   = {shift[14:0], 1'b0};
                     bit_cnt_nxt = 4'd1;
                  end else begin
                     state_nxt   = WR_BYTE;
                     sda_oe_nxt  = 1'b0;
                     sda_out_nxt = 1'b0;
                     bit_cnt_nxt = 4'd0;
                  end
               end
            end
            WR_BYTE: begin
               if (ev_rise) begin
                  shift_nxt   = {shift[14:0], bit_in};
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end else if (ev_fall && bit_cnt == 4'd8) begin
                  bit_cnt_nxt = 4'd0;
                  // Only two data bytes fit the word; anything beyond is refused.
                  if (byte_cnt < 2'd2) begin
                     state_nxt   = WR_ACK;
                     sda_oe_nxt  = 1'b1;
                     sda_out_nxt = 1'b0;
                  end else begin
                     state_nxt  = WAIT_STOP;
                     sda_oe_nxt = 1'b0;
                  end
               end
            end
            WR_ACK: begin
               if (ev_rise) begin
                  byte_cnt_nxt = byte_cnt + 2'd1;
                  if (byte_cnt == 2'd1) begin
                     wr_data_nxt = shift;
                     wr_stb_nxt  = 1'b1;
                  end
               end else if (ev_fall) begin
                  state_nxt   = WR_BYTE;
                  sda_oe_nxt  = 1'b0;
                  sda_out_nxt = 1'b0;
               end
            end
            RD_BYTE: begin
               if (ev_fall) begin
                  if (bit_cnt == 4'd8) begin
                     state_nxt   = RD_ACK;
                     sda_oe_nxt  = 1'b0;
                     sda_out_nxt = 1'b0;
                     bit_cnt_nxt = 4'd0;
                  end else begin
                     sda_oe_nxt  = 1'b1;
                     sda_out_nxt = shift[15];
                     shift_nxt   = {shift[14:0], 1'b0};
                     bit_cnt_nxt = bit_cnt + 4'd1;
                  end
               end
            end
            RD_ACK: begin
               if (ev_rise) begin
                  if (!bit_in && byte_cnt == 2'd0) begin
                     state_nxt    = RD_BYTE;
                     byte_cnt_nxt = 2'd1;
                  end else begin
                     state_nxt = WAIT_STOP;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/i2c_target.md
# i2c_target

Two-wire bus responder and counterpart of the team's IC2 master. Oversamples SCL and SDA on the system clock, detects START/STOP, matches a 7-bit address, and either captures a 16-bit write word or returns a 16-bit read word. Sits between the shared SCL/SDA pads and a local register block.

## Interface
Parameters:
- TARGET_ADDR, 7'h2A, address this target ACKs.

Ports:
- CLK  in  1  system clock; single clock domain, all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- SCL  in  1  bus clock from master; asynchronous to CLK.
- SDA_IN  in  1  bus data line as seen at the pad; asynchronous.
- SDA_OUT  out  1  value driven on SDA when SDA_OE=1.
- SDA_OE  out  1  pad output enable; 0 = released.
- RD_DATA  in  16  word returned to master on a read; sampled at address ACK.
- WR_DATA  out  16  last word received on a write.
- WR_STB  out  1  one-CLK pulse when WR_DATA updates.
- RD_STB  out  1  one-CLK pulse when RD_DATA is latched.
- BUSY  out  1  high from START until STOP/abort.

## Operation
- SCL and SDA_IN pass through 2-flop synchronizers (scl_s, sda_s), plus one delay stage for edge detection.
- START: sda_s falls while scl_s high and unchanged. STOP: sda_s rises while scl_s high and unchanged. If scl_s and sda_s change on the same cycle, only the SCL edge counts.
- Bits sampled on scl_s rising edge, MSB first. SDA_OUT/SDA_OE change only on scl_s falling edge, START, STOP, or RESET.
- Address byte: ADDR[6:0] then RNW (1 = read, 0 = write).
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- IDLE -> ADDR on START. A START in any state (repeated START) -> ADDR, bit count cleared, SDA released.
- STOP in any state -> IDLE, SDA released, BUSY=0.
- ADDR: 8 bits. On the falling edge after bit 8:
  - Match -> ADDR_ACK with SDA_OE=1, SDA_OUT=0.
  - No match -> WAIT_STOP with SDA released.
- ADDR_ACK, write: on the falling edge ending the ACK, release SDA and go to WR_BYTE.
- ADDR_ACK, read: RD_DATA is latched into the shift register, with RD_STB, on the falling edge after bit 8. On the falling edge ending the ACK, drive shift[15] and go to RD_BYTE.
- WR_BYTE: first byte fills [15:8], second byte fills [7:0]. Each byte is ACKed (WR_ACK).
  - After the second byte's ACK rising edge, WR_DATA is updated and WR_STB pulses.
  - A third byte is NACKed (SDA released) and the block goes to WAIT_STOP.
- RD_BYTE: the next bit is driven on each falling edge. After 8 bits, release SDA and go to RD_ACK.
- RD_ACK: sample on the rising edge.
  - Low (ACK) after byte 1 -> RD_BYTE (byte 2).
  - NACK, or the end of byte 2 -> WAIT_STOP, SDA released.
- WAIT_STOP: ignore bits; leave only on STOP or START.
- Reset values: SDA_OE=0, SDA_OUT=0, WR_DATA=0, WR_STB=0, RD_STB=0, BUSY=0, state IDLE.
- RESET mid-transfer aborts immediately; the current bus transaction is ignored until the next START.

## Timing
- Constraint: SCL high and low phases each ≥4 CLK; SDA setup/hold around SCL edges ≥3 CLK.
- Pad-to-action latency: 3 CLK. A raw edge first sampled at CLK edge n gives registered outputs (SDA_OE, SDA_OUT, state) updated at edge n+3.
- WR_STB is asserted at n+3 relative to the rising SCL of the 2nd-byte ACK bit. It lasts exactly 1 CLK.
- RD_STB is asserted at n+3 relative to the falling SCL after address bit 8. It lasts 1 CLK. RD_DATA must be stable on that cycle.
- BUSY rises 3 CLK after the raw START and falls 3 CLK after the raw STOP.

## Configuration
- I2C_TGT_GENCALL_EN defined: address 7'h00 with RNW=0 is ACKed and handled as a normal 16-bit write (WR_DATA/WR_STB). Address 7'h00 with RNW=1 is NACKed.
- Undefined: 7'h00 is treated as any non-matching address (NACK, WAIT_STOP).

## Test plan
- Write 0xA55A to 7'h2A -> ACK at bits 9/18/27; WR_DATA=16'hA55A; exactly one WR_STB pulse; SDA_OE=0 after STOP.
- Read from 7'h2A with RD_DATA=16'h1234, master ACKs byte 1 and NACKs byte 2 -> one RD_STB; bus bits 0x12 then 0x34; SDA released in ACK slots.
- Address 7'h2B, RNW=0 -> SDA_OE stays 0 for all bits; no WR_STB; BUSY drops after STOP.
- Write of 3 bytes 0x11,0x22,0x33 -> third byte NACKed; WR_DATA=16'h1122; one WR_STB.
- RESET asserted mid-read (bit 5 of byte 1) -> next CLK SDA_OE=0, BUSY=0. A following full write of 0xBEEF succeeds.
- With I2C_TGT_GENCALL_EN, write 0x0F0F to 7'h00 -> ACKed, WR_DATA=16'h0F0F. Without the macro -> NACK, WR_DATA unchanged.
